generate_wave: RTL and testbench
================================

# generate_wave

Oscilloscope trace renderer for a 1024×768 XGA display, 1344-clock line period. It sits between the VGA timing generator and the video output. It issues a look-ahead sample-buffer read address from the current scan position, compares each returned sample with the scan row, and produces a registered pixel/colour stream. The VGA sync/blank signals are delayed to stay aligned with that stream. It also pulses `drawStarting` at the last visible pixel so the capture logic can swap or refill the sample buffer.

## Interface
- `H_TOTAL`, 1344, clocks per line (address wrap modulus)
- `H_VISIBLE`, 1024, visible columns
- `V_VISIBLE`, 768, visible rows
- `Y_CENTER`, 384, screen row for sample value 0
- `LOOKAHEAD`, 2, columns of read look-ahead
- `TRACE_COLOR`, 24'h00FF00, trace RGB
- `clock` in 1: pixel clock; all state on rising edge
- `resetN` in 1: asynchronous, active-low reset
- `dataIn` in 12: signed two's-complement sample from buffer RAM, valid one clock after `address`
- `displayX` in 11: current column, 0..1343, increments by 1 each clock
- `displayY` in 10: current row
- `hsync`, `vsync`, `blank` in 1 each: timing-generator outputs, aligned with displayX/Y
- `pixel` out 1: trace hit at the current output position
- `RGBColor` out 24: output colour
- `drawStarting` out 1: one-clock end-of-visible-frame pulse
- `address` out 11: sample-buffer read address
- `wHsync`, `wVsync`, `wBlank` out 1 each: sync/blank delayed to match `RGBColor`

## Operation
- **Address:** `address = (displayX + LOOKAHEAD) mod H_TOTAL`, combinational.
  - 1020→1022, 1021→1023, 1342→0, 1343→1, 0→2, 1→3.
  - Values ≥1024 during horizontal blanking are legal; RAM contents there are don't-care.
- **Sample register:** `sampleReg <= dataIn` every clock.
  - RAM latency 1 + this register 1 = 2 = LOOKAHEAD, so `sampleReg` holds the sample for column `displayX` in the current cycle.
- **Target row:** 13-bit signed, `target = Y_CENTER − sampleReg`. Positive samples plot above centre.
- **Hit:** `hit = (displayY ≥ target−1) && (displayY ≤ target+1)`.
  - Compare in 13-bit signed with zero-extended `displayY`.
  - The trace is 3 rows thick.
  - Targets off-screen simply never match; no clamping.
- **Hit is independent of blanking.** Colour is gated by blank instead.
- **Colour:** `RGBColor = TRACE_COLOR` if hit and blank low, else 24'h000000.
- **Frame strobe:** `drawStarting` is high when `displayX == H_VISIBLE−1 && displayY == V_VISIBLE−1`, else low.

## Timing
- All outputs except `address` are registered, with 1-clock latency from `displayX/Y/hsync/vsync/blank`:
  - `pixel <= hit`, `RGBColor <=` the colour rule, `drawStarting <=` the strobe condition
  - `wHsync <= hsync`, `wVsync <= vsync`, `wBlank <= blank`
- `address` has zero latency (combinational).
- Reset (`resetN` low, asynchronous): `pixel`, `RGBColor`, `drawStarting`, `wHsync`, `wVsync`, `wBlank` and `sampleReg` all go to 0. `address` still follows `displayX`.
- First valid `pixel` after reset release is 2 clocks later, once `sampleReg` is loaded.
- Reset mid-frame: outputs clear immediately. Normal output resumes on the next edges; no frame resynchronisation is needed.
- Address wrap 1343→1 and 1342→0 must be glitch-free; this is pure modular add, with no compare-then-subtract across cycles.

## Structure
- Shared package: H_TOTAL, H_VISIBLE, V_VISIBLE, Y_CENTER, colour constants, and the sample width (12).
- Single flat module, no sub-modules. Optional `wave_compare` helper for the signed ±1 window test.

## Test plan
- **Sync delay:** hsync=vsync=blank=1 for one clock, then 0 → wHsync/wVsync/wBlank high for exactly the following clock.
- **Frame strobe:** (X,Y)=(1023,767) → drawStarting=1 next clock. (1024,767) → drawStarting=0 next clock.
- **Trace window:** sampleReg=80 (dataIn=80 held ≥2 clocks), blank=0; step displayY 302,303,304,305,306 → pixel 0,1,1,1,0 and RGBColor 0,00FF00,00FF00,00FF00,0, each one clock later.
- **Address map:** displayX 1021,1020,1342,1343,0,1 → address 1023,1022,0,1,2,3, same cycle.
- **Blank gating:** as the trace-window test with blank=1 and displayY=304 → pixel=1, RGBColor=0.
- **Reset:** assert resetN=0 mid-stream asynchronously → all registered outputs 0 before the next edge. Release → pixel valid after 2 clocks. Negative sample −100 → hits at rows 483..485.

Source files
------------

// File: rtl/generate_wave_pkg.sv
// Shared constants and the trace-window helper for the XGA oscilloscope trace renderer.
package generate_wave_pkg;

  localparam int H_TOTAL   = 1344;
  localparam int H_VISIBLE = 1024;
  localparam int V_VISIBLE = 768;
  localparam int Y_CENTER  = 384;
  localparam int LOOKAHEAD = 2;

  localparam int SAMPLE_W = 12;
  localparam int X_W      = 11;
  localparam int Y_W      = 10;
  localparam int TGT_W    = SAMPLE_W + 1;
  localparam int RGB_W    = 24;

  localparam logic [RGB_W-1:0] TRACE_COLOR = 24'h00FF00;
  localparam logic [RGB_W-1:0] BLACK_COLOR = 24'h000000;

  // Registered output bundle, kept together so reset and update stay in step.
  typedef struct packed {
    logic             pixel;
    logic [RGB_W-1:0] rgb;
    logic             draw_starting;
    logic             hsync;
    logic             vsync;
    logic             blank;
  } wave_out_t;

  // True when row y lies within one row of target; the trace is three rows thick.
  function automatic logic wave_compare(input logic signed [TGT_W-1:0] target,
                                        input logic [Y_W-1:0] y);
    logic signed [TGT_W-1:0] y_s;
    y_s = signed'({{(TGT_W-Y_W){1'b0}}, y});
    return (y_s >= target - 13'sd1) && (y_s <= target + 13'sd1);
  endfunction

endpackage

// File: rtl/generate_wave.sv
// Oscilloscope trace renderer: look-ahead sample read, row compare, registered
// pixel/colour stream with sync/blank delayed to match.
module generate_wave
  import generate_wave_pkg::*;
(
  input  logic                clock,
  input  logic                resetN,
  input  logic [SAMPLE_W-1:0] dataIn,
  input  logic [X_W-1:0]      displayX,
  input  logic [Y_W-1:0]      displayY,
  input  logic                hsync,
  input  logic                vsync,
  input  logic                blank,
  output logic                pixel,
  output logic [RGB_W-1:0]    RGBColor,
  output logic                drawStarting,
  output logic [X_W-1:0]      address,
  output logic                wHsync,
  output logic                wVsync,
  output logic                wBlank
);

  localparam logic [X_W:0] ADDR_AHEAD = (X_W+1)'(LOOKAHEAD);
  localparam logic [X_W:0] ADDR_MOD   = (X_W+1)'(H_TOTAL);
  localparam logic [X_W-1:0] LAST_X   = X_W'(H_VISIBLE - 1);
  localparam logic [Y_W-1:0] LAST_Y   = Y_W'(V_VISIBLE - 1);
  localparam logic signed [TGT_W-1:0] CENTER = TGT_W'(Y_CENTER);

  logic signed [SAMPLE_W-1:0] sample_d, sample_q;
  wave_out_t                  out_d, out_q;
  logic [X_W:0]               addr_sum;
  logic signed [TGT_W-1:0]    target;
  logic                       hit;

  // One extra bit holds the carry, so the wrap is a single-cycle modular add.
  always_comb begin
    addr_sum = {1'b0, displayX} + ADDR_AHEAD;
    address  = (addr_sum >= ADDR_MOD) ? X_W'(addr_sum - ADDR_MOD) : addr_sum[X_W-1:0];
  end

  // RAM latency plus sample_q equals LOOKAHEAD, so sample_q belongs to displayX now.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sample_d = dataIn;
    target   = CENTER - {sample_q[SAMPLE_W-1], sample_q};
    hit      = wave_compare(target, displayY);

    out_d               = '0;
    out_d.pixel         = hit;
    out_d.rgb           = (hit && !blank) ? TRACE_COLOR : BLACK_COLOR;
    out_d.draw_starting = (displayX == LAST_X) && (displayY == LAST_Y);
    out_d.hsync         = hsync;
    out_d.vsync         = vsync;
    out_d.blank         = blank;
  end

  always_ff @(posedge clock or negedge resetN) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!resetN) begin
      sample_q <= '0;
      out_q    <= '0;
    end else begin
      sample_q <= sample_d;
      out_q    <= out_d;
    end
  end

  assign pixel        = out_q.pixel;
  assign RGBColor     = out_q.rgb;
  assign drawStarting = out_q.draw_starting;
  assign wHsync       = out_q.hsync;
  assign wVsync       = out_q.vsync;
  assign wBlank       = out_q.blank;

endmodule

// File: tb/tb_generate_wave.sv
// Directed self-checking bench for generate_wave with hand-computed expectations.
module tb_generate_wave;

  logic        clock;
  logic        resetN;
  logic [11:0] dataIn;
  logic [10:0] displayX;
  logic [9:0]  displayY;
  logic        hsync, vsync, blank;
  logic        pixel;
  logic [23:0] RGBColor;
  logic        drawStarting;
  logic [10:0] address;
  logic        wHsync, wVsync, wBlank;

  int n_checks = 0;
  int n_pass   = 0;

  generate_wave dut (
    .clock        (clock),
    .resetN       (resetN),
    .dataIn       (dataIn),
    .displayX     (displayX),
    .displayY     (displayY),
    .hsync        (hsync),
    .vsync        (vsync),
    .blank        (blank),
    .pixel        (pixel),
    .RGBColor     (RGBColor),
    .drawStarting (drawStarting),
    .address      (address),
    .wHsync       (wHsync),
    .wVsync       (wVsync),
    .wBlank       (wBlank)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [10:0] addr_x   [6] = '{11'd1021, 11'd1020, 11'd1342, 11'd1343, 11'd0, 11'd1};
  logic [10:0] addr_exp [6] = '{11'd1023, 11'd1022, 11'd0,    11'd1,    11'd2, 11'd3};
  logic [9:0]  win_y    [5] = '{10'd302, 10'd303, 10'd304, 10'd305, 10'd306};
  logic        win_pix  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [9:0]  neg_y    [5] = '{10'd482, 10'd483, 10'd484, 10'd485, 10'd486};
  logic        neg_pix  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    resetN = 1'b0; dataIn = '0; displayX = '0; displayY = '0;
    hsync = 1'b0; vsync = 1'b0; blank = 1'b1;
    #12;
    check("reset_pixel", 32'(pixel), 32'd0);
    check("reset_rgb",   32'(RGBColor), 32'd0);
    check("reset_draw",  32'(drawStarting), 32'd0);
    check("reset_sync",  32'({wHsync, wVsync, wBlank}), 32'd0);
    step();
    resetN = 1'b1;

    // Address map, combinational
    for (int i = 0; i < 6; i++) begin
      displayX = addr_x[i];
      #1;
      check($sformatf("addr_x%0d", addr_x[i]), 32'(address), 32'(addr_exp[i]));
    end

    // Sync delay: one-clock pulse appears exactly one clock later
    displayX = 11'd100; displayY = 10'd0;
    hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
    step();
    hsync = 1'b0; vsync = 1'b0; blank = 1'b0;
    check("sync_hi", 32'({wHsync, wVsync, wBlank}), 32'b111);
    step();
    check("sync_lo", 32'({wHsync, wVsync, wBlank}), 32'b000);

    // Frame strobe
    displayX = 11'd1023; displayY = 10'd767;
    step();
    check("strobe_on", 32'(drawStarting), 32'd1);
    displayX = 11'd1024;
    step();
    check("strobe_off", 32'(drawStarting), 32'd0);

    // Trace window: sample 80 -> target 304, hits rows 303..305
    displayX = 11'd200; blank = 1'b0; dataIn = 12'd80; displayY = 10'd0;
    step();
    for (int i = 0; i < 5; i++) begin
      displayY = win_y[i];
      step();
      check($sformatf("win_pix_y%0d", win_y[i]), 32'(pixel), 32'(win_pix[i]));
      check($sformatf("win_rgb_y%0d", win_y[i]), 32'(RGBColor),
            win_pix[i] ? 32'h00FF00 : 32'h0);
    end

    // Blank gating: hit stays, colour forced black
    displayY = 10'd304; blank = 1'b1;
    step();
    check("blank_pix", 32'(pixel), 32'd1);
    check("blank_rgb", 32'(RGBColor), 32'd0);

    // Mid-stream asynchronous reset with non-zero outputs
    blank = 1'b0; hsync = 1'b1; vsync = 1'b1;
    step();
    check("pre_rst_rgb", 32'(RGBColor), 32'h00FF00);
    check("pre_rst_sync", 32'({wHsync, wVsync}), 32'b11);
    #2 resetN = 1'b0;
    #1;
    check("rst_pixel", 32'(pixel), 32'd0);
    check("rst_rgb",   32'(RGBColor), 32'd0);
    check("rst_sync",  32'({wHsync, wVsync, wBlank, drawStarting}), 32'd0);
    displayX = 11'd1343;
    #1;
    check("rst_addr", 32'(address), 32'd1);
    hsync = 1'b0; vsync = 1'b0;

    // Release: sample -100 -> target 484; first edge still sees the cleared sample
    displayX = 11'd300; displayY = 10'd483; dataIn = 12'hF9C;
    #1 resetN = 1'b1;
    step();
    check("rel_first", 32'(pixel), 32'd0);
    for (int i = 0; i < 5; i++) begin
      displayY = neg_y[i];
      step();
      check($sformatf("neg_pix_y%0d", neg_y[i]), 32'(pixel), 32'(neg_pix[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
